// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one pipelined multiplier among NUM_REQ
// requesters, routing each product back to a one-entry result slot per requester.

module mul_share_slot #(
    parameter int WIDTH_MUL = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  logic                 cap,
    input  logic                 rdy,
    input  logic [WIDTH_MUL-1:0] din,
    output logic                 out_flag,
    output logic                 vld,
    output logic [WIDTH_MUL-1:0] data
);
    // issue/drain and cap/drain are mutually exclusive for one slot: out_flag
    // blocks a new issue until the slot is drained, and a capture only lands
    // in an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_flag <= 1'b0;
            vld      <= 1'b0;
            data     <= '0;
        end else begin
            if (issue) out_flag <= 1'b1;
            if (vld && rdy) begin
                vld      <= 1'b0;
                out_flag <= 1'b0;
            end
            if (cap) begin
                vld  <= 1'b1;
                data <= din;
            end
        end
    end
endmodule

module mul_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = 32,
    parameter int MUL_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [WIDTH_A-1:0]           mul_a,
    output logic [WIDTH_B-1:0]           mul_b,
    input  logic [WIDTH_MUL-1:0]         mul_out,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_REQ*WIDTH_MUL-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic                         busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][WIDTH_A-1:0]   a_v;
    logic [NUM_REQ-1:0][WIDTH_B-1:0]   b_v;
    logic [NUM_REQ-1:0][WIDTH_MUL-1:0] rsp_d;
    logic [NUM_REQ-1:0]                out_flag, elig, issue, cap;
    logic [IDX_W-1:0]                  ptr, g;
    logic                              g_vld;
    logic [MUL_LAT:1]                  vld_pipe;
    logic [IDX_W-1:0]                  idx_pipe [1:MUL_LAT];

    assign a_v  = req_a;
    assign b_v  = req_b;
    assign elig = req_valid & ~out_flag;

    // First eligible index scanning upward from ptr with wrap.
    always_comb begin
        int idx;
        idx   = 0;
        g_vld = 1'b0;
        g     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!g_vld && elig[idx]) begin
                g_vld = 1'b1;
                g     = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        issue = '0;
        cap   = '0;
        if (g_vld) issue[g] = 1'b1;
        if (vld_pipe[MUL_LAT]) cap[idx_pipe[MUL_LAT]] = 1'b1;
    end

    assign req_ready = issue;
    assign mul_a     = g_vld ? a_v[g] : '0;
    assign mul_b     = g_vld ? b_v[g] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (g_vld) begin
            ptr <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
        end
    end

    // Owner tags ride alongside the multiplier; they never stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= MUL_LAT; s++) idx_pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= g_vld;
            idx_pipe[1] <= g;
            for (int s = 2; s <= MUL_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        mul_share_slot #(.WIDTH_MUL(WIDTH_MUL)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .issue    (issue[i]),
            .cap      (cap[i]),
            .rdy      (rsp_ready[i]),
            .din      (mul_out),
            .out_flag (out_flag[i]),
            .vld      (rsp_valid[i]),
            .data     (rsp_d[i])
        );
    end

    assign rsp_data = rsp_d;
    assign busy     = (|vld_pipe) | (|rsp_valid);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter: a spec-level model predicts grants and
// slot occupancy; a monitor checks each returned product against a scoreboard.

module tb_mul_share_arbiter;
    localparam int N   = 4;
    localparam int WA  = 16;
    localparam int WB  = 16;
    localparam int WM  = 32;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*WA-1:0] req_a;
    logic [N*WB-1:0] req_b;
    logic [WA-1:0]   mul_a;
    logic [WB-1:0]   mul_b;
    logic [WM-1:0]   mul_out;
    logic [N*WM-1:0] rsp_data;
    logic            busy;

    mul_share_arbiter #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB),
                        .WIDTH_MUL(WM), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: unsigned product, LAT registered stages, never reset.
    logic [WM-1:0] mp [LAT];
    initial for (int s = 0; s < LAT; s++) mp[s] = '0;
    always @(posedge clk) begin
        mp[0] <= WM'(mul_a) * WM'(mul_b);
        for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
    end
    assign mul_out = mp[LAT-1];

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    typedef struct { int idx; int due; } fl_t;
    typedef struct { logic [WM-1:0] d; int due; } exp_t;

    bit [N-1:0] m_out, m_slot;
    int         m_ptr;
    fl_t        infl [$];
    exp_t       exp_q [N][$];

    // Reference model: one evaluation per cycle, mid-cycle.
    always @(negedge clk) begin : model
        int         g;
        int         idx;
        logic [N-1:0] elig, exp_rdy;
        fl_t        f;
        exp_t       e;
        if (rst) begin
            m_out = '0;
            m_slot = '0;
            m_ptr = 0;
            infl.delete();
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            while (infl.size() > 0 && infl[0].due == cyc_n) begin
                m_slot[infl[0].idx] = 1'b1;
                void'(infl.pop_front());
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(m_slot));
            chk("busy", 64'(busy), 64'((infl.size() > 0) || (m_slot != 0)));
            elig = req_valid & ~m_out;
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && elig[idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (g >= 0) begin
                chk("mul_a", 64'(mul_a), 64'(req_a[g*WA +: WA]));
                chk("mul_b", 64'(mul_b), 64'(req_b[g*WB +: WB]));
            end else begin
                chk("mul_a_idle", 64'(mul_a), 64'(0));
                chk("mul_b_idle", 64'(mul_b), 64'(0));
            end
            for (int i = 0; i < N; i++)
                if (m_slot[i] && rsp_ready[i]) begin
                    m_slot[i] = 1'b0;
                    m_out[i] = 1'b0;
                end
            if (g >= 0) begin
                m_out[g] = 1'b1;
                m_ptr = (g + 1) % N;
                f.idx = g;
                f.due = cyc_n + LAT + 1;
                infl.push_back(f);
                e.d = WM'(req_a[g*WA +: WA]) * WM'(req_b[g*WB +: WB]);
                e.due = cyc_n + LAT + 1;
                exp_q[g].push_back(e);
            end
        end
    end

    // Monitor: pops the scoreboard when a slot fills, checks hold while full.
    logic [N-1:0]  prev_v = '0;
    logic [WM-1:0] held [N];
    always @(negedge clk) begin : mon
        logic [WM-1:0] d;
        exp_t          e;
        if (rst) begin
            prev_v = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                d = rsp_data[i*WM +: WM];
                if (rsp_valid[i] && !prev_v[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid[i]), 64'(0));
                    end else begin
                        e = exp_q[i].pop_front();
                        chk("rsp_data", 64'(d), 64'(e.d));
                        chk("rsp_time", 64'(cyc_n), 64'(e.due));
                    end
                    held[i] = d;
                end else if (rsp_valid[i] && prev_v[i]) begin
                    chk("rsp_hold", 64'(d), 64'(held[i]));
                end
                prev_v[i] = rsp_valid[i];
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(int i, int a, int b);
        req_a[i*WA +: WA] = WA'(a);
        req_b[i*WB +: WB] = WB'(b);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_op(i, int'($urandom), int'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pending;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = '1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_mul_a", 64'(mul_a), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        step(1);

        // single op: 3*5
        req_valid = 4'b0001;
        set_op(0, 3, 5);
        step(1);
        req_valid = '0;
        step(5);

        // fairness: everyone valid
        req_valid = '1;
        repeat (12) begin
            rand_ops();
            step(1);
        end
        req_valid = '0;
        step(5);

        // backpressure on requester 2, then wrap from ptr=3 with 0 and 3 valid
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        set_op(2, 7, 9);
        step(11);
        rsp_ready = '1;
        step(2);
        req_valid = 4'b1001;
        rand_ops();
        step(2);
        req_valid = '0;
        step(5);

        // idle
        step(4);

        // random traffic with random backpressure
        repeat (300) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(3) != 0);
            rand_ops();
            step(1);
        end
        req_valid = '0;
        rsp_ready = '1;
        step(6);

        // reset with operations in flight
        req_valid = 4'b0011;
        rand_ops();
        step(2);
        req_valid = '0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("post_rst_busy", 64'(busy), 64'(0));
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            step(1);
        end
        req_valid = '1;
        repeat (6) begin
            rand_ops();
            step(1);
        end
        req_valid = '0;
        step(8);

        @(negedge clk);
        pending = infl.size();
        for (int i = 0; i < N; i++) pending += exp_q[i].size();
        chk("all_drained", 64'(pending), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
